// File: rtl/avalon_mem_bank_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM memory bank among N_REQ masters.
// Write bursts lock the grant until their last beat; read responses are
// routed back to the issuing master through an in-order tag FIFO.
module avalon_mem_bank_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RSP_FIFO_DEPTH  = 64
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [N_REQ*ADDR_WIDTH-1:0]          req_address,
  input  logic [N_REQ-1:0]                     req_read,
  input  logic [N_REQ-1:0]                     req_write,
  input  logic [N_REQ*BURST_CNT_WIDTH-1:0]     req_burstcount,
  input  logic [N_REQ*DATA_WIDTH-1:0]          req_writedata,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0]      req_byteenable,
  output logic [N_REQ-1:0]                     req_waitrequest,
  output logic [DATA_WIDTH-1:0]                req_readdata,
  output logic [N_REQ-1:0]                     req_readdatavalid,
  input  logic                                 mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]                mem_readdata,
  input  logic                                 mem_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [BURST_CNT_WIDTH-1:0]           mem_burstcount,
  output logic [DATA_WIDTH-1:0]                mem_writedata,
  output logic [DATA_WIDTH/8-1:0]              mem_byteenable,
  output logic                                 err_rsp_underflow
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int BC_W  = BURST_CNT_WIDTH;

  typedef enum logic [1:0] {ARB, HOLD, WBURST} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   beats_left_q, beats_left_d;

  // Per-master views of the flattened request buses
  logic [ADDR_WIDTH-1:0] addr_a   [N_REQ];
  logic [BC_W-1:0]       bc_a     [N_REQ];
  logic [BC_W-1:0]       bc_eff_a [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_a  [N_REQ];
  logic [BE_W-1:0]       be_a     [N_REQ];
  logic [N_REQ-1:0]      elig;

  // Tag FIFO
  logic [ID_W-1:0]  tag_id_q [RSP_FIFO_DEPTH];
  logic [BC_W-1:0]  tag_bc_q [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [BC_W-1:0]  rsp_beat_q;
  logic             err_q;
  logic             fifo_full, fifo_empty, push, pop, rsp_valid;

  logic             win_valid;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  sel;
  logic             active, cmd_rd, cmd_wr, accept, complete;
  int               idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_a[gi]   = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign bc_a[gi]     = req_burstcount[gi*BC_W +: BC_W];
      // burstcount 0 counts as a single beat for tags and beat counting
      assign bc_eff_a[gi] = (bc_a[gi] == '0) ? BC_W'(1) : bc_a[gi];
      assign wdata_a[gi]  = req_writedata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign be_a[gi]     = req_byteenable[gi*BE_W +: BE_W];
      // Writes always compete; reads only when a tag slot is free
      assign elig[gi]     = req_write[gi] | (req_read[gi] & ~fifo_full);
    end
  endgenerate

  assign fifo_full  = (count_q == (PTR_W+1)'(RSP_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Round-robin search: first eligible master at or after rr_ptr
  always_comb begin
    win_valid = 1'b0;
    win_id    = rr_ptr_q;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_valid && elig[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Grant FSM next state and command selection
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    sel          = grant_q;
    active       = 1'b0;
    cmd_rd       = 1'b0;
    cmd_wr       = 1'b0;
    complete     = 1'b0;
    case (state_q)
      ARB: begin
        sel    = win_id;
        active = win_valid;
        cmd_wr = win_valid & req_write[win_id];
        cmd_rd = win_valid & req_read[win_id] & ~req_write[win_id];
      end
      HOLD: begin
        active = 1'b1;
        cmd_wr = req_write[grant_q];
        cmd_rd = req_read[grant_q] & ~req_write[grant_q];
      end
      WBURST: begin
        active = 1'b1;
        cmd_wr = req_write[grant_q];
      end
      default: ;
    endcase
    accept = (cmd_rd | cmd_wr) & ~mem_waitrequest;
    case (state_q)
      ARB: begin
        if (active) begin
          grant_d = win_id;
          if (mem_waitrequest) begin
            state_d = HOLD;
          end else if (cmd_wr && bc_eff_a[win_id] > BC_W'(1)) begin
            state_d      = WBURST;
            beats_left_d = bc_eff_a[win_id] - BC_W'(1);
          end else begin
            complete = 1'b1;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          if (cmd_wr && bc_eff_a[grant_q] > BC_W'(1)) begin
            state_d      = WBURST;
            beats_left_d = bc_eff_a[grant_q] - BC_W'(1);
          end else begin
            complete = 1'b1;
          end
        end else if (!cmd_rd && !cmd_wr) begin
          // Master withdrew its stalled command: re-arbitrate without advancing
          state_d = ARB;
        end
      end
      WBURST: begin
        if (accept) begin
          if (beats_left_q == BC_W'(1)) complete = 1'b1;
          else beats_left_d = beats_left_q - BC_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
    if (complete) begin
      state_d  = ARB;
      rr_ptr_d = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);
    end
  end

  // Command mux to the bank; strobes forced low while in reset
  assign mem_address    = addr_a[sel];
  assign mem_burstcount = bc_a[sel];
  assign mem_writedata  = wdata_a[sel];
  assign mem_byteenable = be_a[sel];
  assign mem_read       = reset_n & cmd_rd;
  assign mem_write      = reset_n & cmd_wr;

  // Only the granted master sees the bank stall; everyone else waits
  always_comb begin
    req_waitrequest = '1;
    if (reset_n && active) req_waitrequest[sel] = mem_waitrequest;
  end

  assign push      = accept & cmd_rd;
  assign rsp_valid = mem_readdatavalid & ~fifo_empty;
  assign pop       = rsp_valid & (rsp_beat_q == tag_bc_q[rd_ptr_q] - BC_W'(1));

  // Route each returning beat to the master at the head of the tag FIFO
  always_comb begin
    req_readdatavalid = '0;
    if (reset_n && rsp_valid) req_readdatavalid[tag_id_q[rd_ptr_q]] = 1'b1;
  end

  assign req_readdata      = mem_readdata;
  assign err_rsp_underflow = err_q;

  // Tag storage: plain memory, contents are meaningless outside count_q
  always_ff @(posedge clk) begin
    if (push) begin
      tag_id_q[wr_ptr_q] <= sel;
      tag_bc_q[wr_ptr_q] <= bc_eff_a[sel];
    end
  end

  // FSM, pointers, occupancy and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_beat_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (pop)            rsp_beat_q <= '0;
      else if (rsp_valid) rsp_beat_q <= rsp_beat_q + BC_W'(1);
      if (mem_readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_mem_bank_arbiter.sv
// Directed bench for avalon_mem_bank_arbiter (2 masters, 4-deep tag FIFO).
module tb_avalon_mem_bank_arbiter;
  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N*AW-1:0]   req_address;
  logic [N-1:0]      req_read, req_write;
  logic [N*BW-1:0]   req_burstcount;
  logic [N*DW-1:0]   req_writedata;
  logic [N*DW/8-1:0] req_byteenable;
  logic [N-1:0]      req_waitrequest;
  logic [DW-1:0]     req_readdata;
  logic [N-1:0]      req_readdatavalid;
  logic              mem_waitrequest;
  logic [DW-1:0]     mem_readdata;
  logic              mem_readdatavalid;
  logic [AW-1:0]     mem_address;
  logic              mem_read, mem_write;
  logic [BW-1:0]     mem_burstcount;
  logic [DW-1:0]     mem_writedata;
  logic [DW/8-1:0]   mem_byteenable;
  logic              err_rsp_underflow;

  int checks = 0;
  int errors = 0;

  avalon_mem_bank_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BURST_CNT_WIDTH(BW), .RSP_FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_burstcount(req_burstcount), .req_writedata(req_writedata),
    .req_byteenable(req_byteenable), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_burstcount(mem_burstcount),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .err_rsp_underflow(err_rsp_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen 2 ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset_n           = 1'b0;
    req_address       = {16'h0200, 16'h0100};
    req_read          = 2'b11;
    req_write         = 2'b00;
    req_burstcount    = {4'd1, 4'd1};
    req_writedata     = {32'h1111_0000, 32'h0000_1111};
    req_byteenable    = '1;
    mem_waitrequest   = 1'b0;
    mem_readdata      = '0;
    mem_readdatavalid = 1'b0;

    // Reset state with both masters requesting
    settle();
    chk("rst_waitreq", 64'(req_waitrequest), 64'h3);
    chk("rst_mem_read", 64'(mem_read), 64'h0);
    chk("rst_mem_write", 64'(mem_write), 64'h0);
    chk("rst_rdv", 64'(req_readdatavalid), 64'h0);
    chk("rst_err", 64'(err_rsp_underflow), 64'h0);
    cyc();
    reset_n = 1'b1;

    // Alternating single reads: grants 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("alt_mem_read", 64'(mem_read), 64'h1);
      chk("alt_addr", 64'(mem_address), (i % 2 == 0) ? 64'h100 : 64'h200);
      chk("alt_waitreq", 64'(req_waitrequest), (i % 2 == 0) ? 64'h2 : 64'h1);
      $display("alt read %0d: addr=%0h waitreq=%b", i, mem_address, req_waitrequest);
      cyc();
    end
    req_read = 2'b00;
    // Responses come back to issuers in order
    for (int i = 0; i < 4; i++) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = 32'hA0 + 32'(i);
      settle();
      chk("alt_rdv", 64'(req_readdatavalid), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("alt_rdata", 64'(req_readdata), 64'hA0 + 64'(i));
      $display("alt rsp %0d: rdv=%b data=%0h", i, req_readdatavalid, req_readdata);
      cyc();
    end
    mem_readdatavalid = 1'b0;

    // Master 0 four-beat write burst against master 1 read
    req_write      = 2'b01;
    req_read       = 2'b10;
    req_burstcount = {4'd1, 4'd4};
    for (int i = 0; i < 4; i++) begin
      req_writedata[31:0] = 32'hD0 + 32'(i);
      settle();
      chk("wb_mem_write", 64'(mem_write), 64'h1);
      chk("wb_mem_read", 64'(mem_read), 64'h0);
      chk("wb_waitreq", 64'(req_waitrequest), 64'h2);
      chk("wb_wdata", 64'(mem_writedata), 64'hD0 + 64'(i));
      if (i == 0) chk("wb_bcount", 64'(mem_burstcount), 64'h4);
      $display("burst beat %0d: wdata=%0h waitreq=%b", i, mem_writedata, req_waitrequest);
      cyc();
    end
    req_write = 2'b00;
    settle();
    chk("wb_next_read", 64'(mem_read), 64'h1);
    chk("wb_next_addr", 64'(mem_address), 64'h200);
    chk("wb_next_waitreq", 64'(req_waitrequest), 64'h1);
    $display("after burst: master1 read addr=%0h", mem_address);
    cyc();
    req_read = 2'b00;
    mem_readdatavalid = 1'b1;
    mem_readdata = 32'hBEEF;
    settle();
    chk("wb_rsp_rdv", 64'(req_readdatavalid), 64'h2);
    cyc();
    mem_readdatavalid = 1'b0;

    // Single write from master 0 moves the pointer to master 1
    req_write      = 2'b01;
    req_burstcount = {4'd1, 4'd1};
    req_address    = {16'h0240, 16'h0300};
    settle();
    chk("sw_mem_write", 64'(mem_write), 64'h1);
    chk("sw_waitreq", 64'(req_waitrequest), 64'h2);
    cyc();

    // Master 1 read stalled five cycles while master 0 keeps requesting
    req_read        = 2'b10;
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hold_addr", 64'(mem_address), 64'h240);
      chk("hold_read", 64'(mem_read), 64'h1);
      chk("hold_write", 64'(mem_write), 64'h0);
      chk("hold_waitreq", 64'(req_waitrequest), 64'h3);
      $display("hold cycle %0d: addr=%0h read=%b", i, mem_address, mem_read);
      cyc();
    end
    mem_waitrequest = 1'b0;
    settle();
    chk("hold_acc_read", 64'(mem_read), 64'h1);
    chk("hold_acc_addr", 64'(mem_address), 64'h240);
    chk("hold_acc_waitreq", 64'(req_waitrequest), 64'h1);
    cyc();
    req_read = 2'b00;
    settle();
    chk("hold_m0_write", 64'(mem_write), 64'h1);
    chk("hold_m0_addr", 64'(mem_address), 64'h300);
    chk("hold_m0_waitreq", 64'(req_waitrequest), 64'h2);
    cyc();
    req_write = 2'b00;
    mem_readdatavalid = 1'b1;
    settle();
    chk("hold_rsp_rdv", 64'(req_readdatavalid), 64'h2);
    cyc();
    mem_readdatavalid = 1'b0;

    // Fill the tag FIFO with four 2-beat reads from master 1
    req_read       = 2'b10;
    req_address    = {16'h0280, 16'h0300};
    req_burstcount = {4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("fill_read", 64'(mem_read), 64'h1);
      chk("fill_waitreq", 64'(req_waitrequest), 64'h1);
      $display("fill read %0d accepted", i);
      cyc();
    end
    // Full: read stalls, a write from master 0 still goes through
    req_write = 2'b01;
    settle();
    chk("full_read", 64'(mem_read), 64'h0);
    chk("full_write", 64'(mem_write), 64'h1);
    chk("full_waitreq", 64'(req_waitrequest), 64'h2);
    cyc();
    req_write = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mem_readdatavalid = 1'b1;
      settle();
      chk("full_rsp_rdv", 64'(req_readdatavalid), 64'h2);
      chk("full_rsp_read", 64'(mem_read), 64'h0);
      chk("full_rsp_waitreq", 64'(req_waitrequest), 64'h3);
      cyc();
    end
    mem_readdatavalid = 1'b0;
    settle();
    chk("unfull_read", 64'(mem_read), 64'h1);
    chk("unfull_waitreq", 64'(req_waitrequest), 64'h1);
    chk("unfull_bcount", 64'(mem_burstcount), 64'h2);
    $display("fifth read accepted after two beats");
    cyc();
    req_read = 2'b00;

    // Reset discards outstanding reads
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    settle();
    chk("postrst_err", 64'(err_rsp_underflow), 64'h0);

    // Response with nothing outstanding
    mem_readdatavalid = 1'b1;
    settle();
    chk("uf_rdv", 64'(req_readdatavalid), 64'h0);
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    chk("uf_err_set", 64'(err_rsp_underflow), 64'h1);
    cyc();
    settle();
    chk("uf_err_sticky", 64'(err_rsp_underflow), 64'h1);
    reset_n = 1'b0;
    settle();
    chk("uf_err_clear", 64'(err_rsp_underflow), 64'h0);
    $display("underflow flag set and cleared by reset");
    cyc();
    reset_n = 1'b1;

    // Reset during beat 2 of a 4-beat write
    req_write      = 2'b01;
    req_read       = 2'b10;
    req_burstcount = {4'd1, 4'd4};
    settle();
    chk("rb_beat1_write", 64'(mem_write), 64'h1);
    cyc();
    settle();
    chk("rb_beat2_write", 64'(mem_write), 64'h1);
    reset_n = 1'b0;
    settle();
    chk("rb_rst_waitreq", 64'(req_waitrequest), 64'h3);
    chk("rb_rst_write", 64'(mem_write), 64'h0);
    chk("rb_rst_read", 64'(mem_read), 64'h0);
    cyc();
    reset_n = 1'b1;
    settle();
    chk("rb_post_write", 64'(mem_write), 64'h1);
    chk("rb_post_waitreq", 64'(req_waitrequest), 64'h2);
    chk("rb_post_bcount", 64'(mem_burstcount), 64'h4);
    $display("after reset release: grant waitreq=%b", req_waitrequest);
    cyc();
    req_write = 2'b00;
    req_read  = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
